evt_wait_sched: RTL

Per-channel wait-time scheduler that directly feeds the clock-gate indicator stage. It accepts timing commands over a valid/ready interface, buffers them in a 2-entry FIFO and runs one countdown timer per channel. It drives the per-channel remaining-time vector `event_proc`, the last applied command type `cmd_type_M`, the loaded wait times `proc_rel_time` and the clock-gate indication `ckg_ind` consumed downstream.

---
 rtl/evt_wait_pkg.sv | 24 ++
 rtl/evt_wait_fifo.sv | 71 +++++++
 rtl/evt_wait_sched.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/evt_wait_pkg.sv
// Shared types for the event wait scheduler: command codes, channel states, command record.
// Command record fields are sized for the largest supported build (NCH <= 8, PARA <= 16).
package evt_wait_pkg;

  localparam logic [4:0] CMD_REL    = 5'd1;
  localparam logic [4:0] CMD_EXT    = 5'd2;
  localparam logic [4:0] CMD_CANCEL = 5'd3;

  localparam int CMD_CH_W   = 3;
  localparam int CMD_TIME_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FIRE = 2'd2
  } ch_state_e;

  typedef struct packed {
    logic [4:0]            kind;
    logic [CMD_CH_W-1:0]   ch;
    logic [CMD_TIME_W-1:0] wtime;
  } cmd_t;

endpackage

// File: rtl/evt_wait_fifo.sv
// Two-entry command FIFO; full/empty are registered, empty_next exposes the post-update occupancy.
module evt_wait_fifo
  import evt_wait_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty,
  output logic empty_next
);

  cmd_t       mem_r [2];
  logic       wr_ptr_r;
  logic       rd_ptr_r;
  logic [1:0] cnt_r;
  logic [1:0] cnt_nxt_s;
  logic       full_r;
  logic       empty_r;
  logic       push_ok_s;
  logic       pop_ok_s;

  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop & ~empty_r;

  // occupancy after this cycle's push/pop
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_nxt_s = cnt_r + 2'd1;
      2'b01:   cnt_nxt_s = cnt_r - 2'd1;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // pointers and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= ~wr_ptr_r;
      if (pop_ok_s)  rd_ptr_r <= ~rd_ptr_r;
      cnt_r   <= cnt_nxt_s;
      full_r  <= (cnt_nxt_s == 2'd2);
      empty_r <= (cnt_nxt_s == 2'd0);
    end
  end

  // storage
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r[0] <= '0;
      mem_r[1] <= '0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout       = mem_r[rd_ptr_r];
  assign full       = full_r;
  assign empty      = empty_r;
  assign empty_next = (cnt_nxt_s == 2'd0);

endmodule

// File: rtl/evt_wait_sched.sv
// Per-channel wait-time scheduler feeding the clock-gate indicator stage.
// Optional build macro EVT_WAIT_SAT_EN: EXT saturates instead of wrapping.
module evt_wait_sched
  import evt_wait_pkg::*;
#(
  parameter  int PARA = 2,
  parameter  int NCH  = 2,
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [4:0]                cmd_type,
  input  logic [CHW-1:0]            cmd_ch,
  input  logic [PARA-1:0]           cmd_time,
  input  logic                      sched_en,
  output logic [4:0]                cmd_type_M,
  output logic [NCH-1:0][PARA-1:0]  proc_rel_time,
  output logic [NCH-1:0][PARA-1:0]  event_proc,
  output logic [NCH-1:0]            evt_done,
  output logic                      ckg_ind
);

  function automatic logic [PARA-1:0] ext_add(input logic [PARA-1:0] a, input logic [PARA-1:0] b);
`ifdef EVT_WAIT_SAT_EN
    logic [PARA:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[PARA]) ext_add = '1;
    else           ext_add = sum[PARA-1:0];
`else
    ext_add = a + b;
`endif
  endfunction

  cmd_t             push_cmd_s;
  cmd_t             head_s;
  logic             full_s;
  logic             empty_s;
  logic             empty_nxt_s;
  logic             pop_s;
  logic             unused_head_s;
  logic [NCH-1:0]   idle_now_s;
  logic [NCH-1:0]   idle_nxt_s;
  logic [4:0]       cmd_type_r;
  logic             ckg_r;

  assign push_cmd_s = '{kind: cmd_type, ch: CMD_CH_W'(cmd_ch), wtime: CMD_TIME_W'(cmd_time)};
  assign pop_s      = sched_en & ~empty_s;
  assign cmd_ready  = ~full_s;
  // upper time bits are zero-extension only
  assign unused_head_s = ^head_s;

  evt_wait_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (cmd_valid),
    .pop        (pop_s),
    .din        (push_cmd_s),
    .dout       (head_s),
    .full       (full_s),
    .empty      (empty_s),
    .empty_next (empty_nxt_s)
  );

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e       state_r, state_nxt_s;
    logic [PARA-1:0] cnt_r, cnt_nxt_s;
    logic [PARA-1:0] prt_r, prt_nxt_s;
    logic [PARA-1:0] tim_s;
    logic            done_r;
    logic            hit_s;

    assign tim_s = head_s.wtime[PARA-1:0];
    // NOPs and unknown types fall through to the free-running timer path
    assign hit_s = pop_s && (head_s.ch == CMD_CH_W'(i)) &&
                   ((head_s.kind == CMD_REL) || (head_s.kind == CMD_EXT) ||
                    (head_s.kind == CMD_CANCEL));

    // channel next state: an applied command overrides countdown/expiry
    always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      prt_nxt_s   = prt_r;
      if (hit_s) begin
        case (head_s.kind)
          CMD_REL: begin
            state_nxt_s = WAIT;
            cnt_nxt_s   = tim_s;
            prt_nxt_s   = tim_s;
          end
          CMD_EXT: begin
            state_nxt_s = WAIT;
            if (state_r == WAIT) begin
              cnt_nxt_s = ext_add(cnt_r, tim_s);
            end else begin
              cnt_nxt_s = tim_s;
              prt_nxt_s = tim_s;
            end
          end
          CMD_CANCEL: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
          end
          default: state_nxt_s = state_r;
        endcase
      end else begin
        case (state_r)
          IDLE: state_nxt_s = IDLE;
          WAIT: begin
            if (sched_en) begin
              if (cnt_r == '0) state_nxt_s = FIRE;
              else             cnt_nxt_s   = cnt_r - PARA'(1'b1);
            end else begin
              state_nxt_s = WAIT;
            end
          end
          FIRE: state_nxt_s = IDLE;
          default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
          end
        endcase
      end
    end

    // channel registers
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= IDLE;
        cnt_r   <= '0;
        prt_r   <= '0;
        done_r  <= 1'b0;
      end else begin
        state_r <= state_nxt_s;
        cnt_r   <= cnt_nxt_s;
        prt_r   <= prt_nxt_s;
        done_r  <= (state_nxt_s == FIRE);
      end
    end

    assign idle_now_s[i]    = (state_r == IDLE);
    assign idle_nxt_s[i]    = (state_nxt_s == IDLE);
    assign event_proc[i]    = cnt_r;
    assign proc_rel_time[i] = prt_r;
    assign evt_done[i]      = done_r;
  end

  // gate indication needs channels and FIFO quiet both now and next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_type_r <= 5'd0;
      ckg_r      <= 1'b1;
    end else begin
      if (pop_s) cmd_type_r <= head_s.kind;
      ckg_r <= (&idle_now_s) & (&idle_nxt_s) & empty_s & empty_nxt_s;
    end
  end

  assign cmd_type_M = cmd_type_r;
  assign ckg_ind    = ckg_r;

endmodule
